// File: rtl/pe_req_ctrl.sv
// rtl/pe_req_ctrl.sv - Wishbone request controller feeding an 8-input priority encoder
module pe_req_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  req_i,
    output logic [7:0]  pe_in,
    output logic        pe_en,
    input  logic [2:0]  pe_code,
    input  logic        pe_gs,
    input  logic        pe_eno,
    output logic        irq_o
);

    localparam logic [1:0] REG_REQ  = 2'd0;
    localparam logic [1:0] REG_CLR  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_CODE = 2'd3;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]  edge_q;
    logic [7:0]  rise;
    logic [7:0]  req_q;
    logic [7:0]  req_next;
    logic [7:0]  set_mask;
    logic [7:0]  clr_mask;
    logic        ctrl_en;
    logic        ctrl_pop_en;
    logic        hit;
    logic        wr;
    logic        rd;
    logic        pop;
    logic [1:0]  reg_sel;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    assign hit     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                     (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];
    assign wr      = hit & wbs_we_i;
    assign rd      = hit & ~wbs_we_i;
    assign pop     = rd & (reg_sel == REG_CODE) & ctrl_pop_en & pe_gs;

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Sets are OR-ed in after clears so a same-cycle set always wins.
    always_comb begin
        set_mask = rise;
        clr_mask = 8'h00;
        if (wr && wbs_sel_i[0] && reg_sel == REG_REQ)
            set_mask = set_mask | wbs_dat_i[7:0];
        if (wr && wbs_sel_i[0] && reg_sel == REG_CLR)
            clr_mask = wbs_dat_i[7:0];
        if (pop)
            clr_mask = clr_mask | (8'h01 << pe_code);
        req_next = (req_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_REQ:  rdata = {24'h0, req_q};
            REG_CLR:  rdata = 32'h0;
            REG_CTRL: rdata = {30'h0, ctrl_pop_en, ctrl_en};
            REG_CODE: rdata = {27'h0, pe_eno, pe_gs, pe_code};
            default:  rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
            edge_q <= 8'h00;
        end else begin
            sync_q[0] <= req_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_q       <= 8'h00;
            ctrl_en     <= 1'b0;
            ctrl_pop_en <= 1'b1;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            irq_o       <= 1'b0;
        end else begin
            req_q     <= req_next;
            wbs_ack_o <= hit;
            irq_o     <= ctrl_en & (|req_q);
            if (hit)
                wbs_dat_o <= wbs_we_i ? 32'h0 : rdata;
            if (wr && wbs_sel_i[0] && reg_sel == REG_CTRL) begin
                ctrl_en     <= wbs_dat_i[0];
                ctrl_pop_en <= wbs_dat_i[1];
            end
        end
    end

    assign pe_in = req_q;
    assign pe_en = ctrl_en;

endmodule

// File: tb/tb_pe_req_ctrl.sv
// tb/tb_pe_req_ctrl.sv - scoreboard bench for pe_req_ctrl with a behavioural encoder
module tb_pe_req_ctrl;

    localparam logic [31:0] A_REQ  = 32'h3000_0000;
    localparam logic [31:0] A_CLR  = 32'h3000_0004;
    localparam logic [31:0] A_CTRL = 32'h3000_0008;
    localparam logic [31:0] A_CODE = 32'h3000_000C;
    localparam logic [31:0] A_BAD  = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  req_lines = 8'h00;
    logic [7:0]  pe_in;
    logic        pe_en;
    logic [2:0]  pe_code;
    logic        pe_gs;
    logic        pe_eno;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    pe_req_ctrl #(.BASE_ADDR(32'h3000_0000), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .req_i    (req_lines),
        .pe_in    (pe_in),
        .pe_en    (pe_en),
        .pe_code  (pe_code),
        .pe_gs    (pe_gs),
        .pe_eno   (pe_eno),
        .irq_o    (irq)
    );

    // Encoder: highest set bit wins.
    always_comb begin
        pe_code = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pe_in[i]) pe_code = 3'(i);
        pe_gs  = pe_en & (|pe_in);
        pe_eno = pe_en & ~(|pe_in);
    end

    always @(negedge clk) begin
        if (ack) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: ack seen with nothing outstanding, dat=%08h", rdat);
            end else begin
                logic [31:0] e;
                bit          c;
                string       n;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = name_q.pop_front();
                if (c) begin
                    vectors++;
                    if (rdat !== e) begin
                        miscompares++;
                        $display("FAIL %s: got %08h expected %08h", n, rdat, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [31:0] e, input bit c,
                             input string name);
        bit got;
        exp_q.push_back(e);
        chk_q.push_back(c);
        name_q.push_back(name);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no ack expected ack within 8 cycles", name);
            void'(exp_q.pop_back());
            void'(chk_q.pop_back());
            void'(name_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
        wb_access(1'b1, a, d, 4'h1, 32'h0, 1'b0, name);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
        wb_access(1'b0, a, 32'h0, 4'hF, e, 1'b1, name);
    endtask

    initial begin
        bit seen;

        // 1: reset values
        tick(3);
        rst = 1'b0;
        check("rst_pe_in", {24'h0, pe_in}, 32'h0);
        check("rst_pe_en", {31'h0, pe_en}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rd(A_CTRL, 32'h2, "rd_ctrl_reset");

        // 2: pop sequence
        wr(A_CTRL, 32'h3, "wr_ctrl");
        wr(A_REQ, 32'h24, "wr_req");
        check("irq_req24", {31'h0, irq}, 32'h1);
        rd(A_CODE, 32'h0D, "code_first");
        check("pe_in_after_pop1", {24'h0, pe_in}, 32'h04);
        rd(A_CODE, 32'h0A, "code_second");
        rd(A_CODE, 32'h10, "code_empty");
        check("pe_in_after_pop2", {24'h0, pe_in}, 32'h00);
        check("irq_after_pops", {31'h0, irq}, 32'h0);

        // 3: external edge through synchroniser
        req_lines = 8'h80;
        tick(2);
        check("req7_early", {24'h0, pe_in}, 32'h00);
        tick(1);
        check("req7_set", {24'h0, pe_in}, 32'h80);
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        wr(A_CLR, 32'h80, "clr_req7");
        check("req7_cleared", {24'h0, pe_in}, 32'h00);
        check("irq_fall", {31'h0, irq}, 32'h0);
        tick(5);
        check("level_no_reset", {24'h0, pe_in}, 32'h00);
        req_lines = 8'h00;
        tick(3);

        // 4: edge set beats CLR in the same cycle
        req_lines = 8'h01;
        tick(2);
        wr(A_CLR, 32'h01, "clr_vs_edge");
        check("set_beats_clr", {24'h0, pe_in}, 32'h01);
        rd(A_REQ, 32'h01, "rd_req_after_race");
        req_lines = 8'h00;
        tick(3);

        // 5: pop disabled
        wr(A_CTRL, 32'h1, "wr_ctrl_nopop");
        rd(A_CODE, 32'h08, "code_nopop1");
        rd(A_CODE, 32'h08, "code_nopop2");
        rd(A_REQ, 32'h01, "rd_req_nopop");
        check("irq_nopop", {31'h0, irq}, 32'h1);

        // 6: byte select, bad address, reset during pending access
        wb_access(1'b1, A_REQ, 32'hFF, 4'b0010, 32'h0, 1'b0, "wr_sel_masked");
        rd(A_REQ, 32'h01, "rd_req_sel_masked");
        rd(A_CTRL, 32'h1, "rd_ctrl_sel_masked");

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_BAD; sel = 4'hF;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        check("bad_addr_no_ack", {31'h0, seen}, 32'h0);
        tick(1);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL; sel = 4'hF;
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        tick(1);
        rst = 1'b0;
        check("rst_mid_no_ack", {31'h0, seen}, 32'h0);
        check("rst_mid_pe_in", {24'h0, pe_in}, 32'h0);
        check("rst_mid_pe_en", {31'h0, pe_en}, 32'h0);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        check("rst_mid_dat", rdat, 32'h0);
        rd(A_CTRL, 32'h2, "rd_ctrl_after_rst");
        rd(A_REQ, 32'h0, "rd_req_after_rst");

        tick(3);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_req_ctrl.md
Name: pe_req_ctrl

Overview:
- Wishbone-facing request controller that sits directly upstream of the 8-input priority encoder and feeds its `io_in`/`io_en` inputs.
- Collects request bits in a sticky register. Bits are set by software writes or by rising edges on external request lines.
- Reads back the encoder's code, `gs` and `eno` results.
- Optionally clears the bit being serviced when the code is read ("pop"), which makes encoder + controller a small interrupt controller.

Parameters:
- BASE_ADDR, 32'h3000_0000, block base address; `wbs_adr_i[31:4]` must equal `BASE_ADDR[31:4]`.
- SYNC_STAGES, 2, synchroniser depth on `req_i` (minimum 2).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; only `sel[0]` is used.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- req_i  in  8  asynchronous external request lines, active-high.
- pe_in  out  8  drives encoder `io_in`; equals REQ register.
- pe_en  out  1  drives encoder `io_en`; equals CTRL.en.
- pe_code  in  3  encoder code output.
- pe_gs  in  1  encoder group-select.
- pe_eno  in  1  encoder enable-out.
- irq_o  out  1  registered interrupt request.

Behaviour:
- Clock/reset: one clock, `wb_clk_i`. Reset `wb_rst_i` is synchronous, active-high.
- Reset values:
  - REQ=0, CTRL.en=0, CTRL.pop_en=1.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0.
  - Synchroniser and edge-detect flops = 0, so a line already high at reset release does not fire.
- Encoder contract (combinational, external to this block):
  - `pe_code` = index of highest set bit of `pe_in`.
  - `pe_gs` = `pe_en` & |`pe_in`.
  - `pe_eno` = `pe_en` & ~|`pe_in`.
- Wishbone classic handshake:
  - `hit` = cyc & stb & address match & ~ack.
  - `ack` is registered: high exactly one cycle, the cycle after `hit`. It then drops for at least one cycle, so back-to-back accesses take 2 cycles each.
  - Non-matching addresses are never acked.
  - `wbs_dat_o` is registered with `ack` and held until the next ack. Its upper unused bits are 0.
- Register map (`wbs_adr_i[3:2]`):
  - 0 REQ: read returns {24'b0, REQ}. Write with `sel[0]` performs REQ |= dat[7:0] (set-only).
  - 1 CLR: write with `sel[0]` clears the REQ bits where dat[7:0]=1. Reads return 0.
  - 2 CTRL: bit0 en, bit1 pop_en. Read/write; write requires `sel[0]`.
  - 3 CODE: read-only. Returns {27'b0, pe_eno, pe_gs, pe_code} as sampled in the `hit` cycle. Writes are acked and ignored.
- Pop: on a CODE read `hit` with pop_en=1 and pe_gs=1, clear REQ[pe_code] at the same clock edge. The read data reflects the pre-clear value.
- External requests:
  - `req_i` passes through SYNC_STAGES flops, then a rising-edge detector.
  - An edge on bit k sets REQ[k] one cycle after the last synchroniser stage.
  - Levels held high do not re-set a bit after it is cleared.
- Simultaneous events on the same bit in the same cycle:
  - Set (edge or REQ write) beats clear (CLR write or pop).
  - Edge and REQ write simply OR.
- `irq_o` is registered: it is high the cycle after (CTRL.en & |REQ) is true, and low the cycle after it becomes false.
- Reset mid-transaction:
  - `ack` is forced to 0.
  - A pending `hit` is dropped.
  - The master must re-issue the access.

Test Plan:
1. Reset, then read CTRL (adr 0x3000_0008) -> ack 1 cycle later with dat=0x2. `irq_o`=0, `pe_in`=0x00, `pe_en`=0.
2. Write CTRL=0x3, write REQ=0x24, read CODE -> dat=0x0D (gs=1, code=5). REQ becomes 0x04. A second CODE read returns 0x0A; a third returns 0x10 (eno=1, gs=0).
3. en=1, pulse `req_i[7]` high and hold -> REQ[7] set SYNC_STAGES+1 cycles after the edge. `irq_o` rises the next cycle. Write CLR=0x80 -> REQ=0 and `irq_o` falls. Holding `req_i[7]` high does not re-set REQ[7].
4. In one cycle, issue a CLR write of 0x01 while a `req_i[0]` edge reaches the detector -> REQ[0] remains 1.
5. pop_en=0, REQ=0x01, read CODE twice -> both reads return 0x08 and REQ stays 0x01.
6. Write with `sel`=4'b0010 -> acked, no register change. Access to 0x3000_0010 -> no ack ever. Assert `wb_rst_i` during the ack-pending cycle -> `ack` stays 0 and all registers return to reset values.
